regfile_mp: RTL and testbench

- Parametrised successor of the single-write, two-read register file.
- Features:
  - configurable data width, register count and number of read ports;
  - optional write-to-read bypass;
  - per-register busy scoreboard that lets the pipelined core detect RAW hazards against in-flight writebacks.
- Sits in decode (reads, issue) and writeback (write) stages of the pipelined processor.

---
 rtl/rf_pkg.sv | 18 +
 rtl/regfile_mp_if.sv | 31 +++
 rtl/rf_read_port.sv | 39 +++
 rtl/regfile_mp.sv | 68 ++++++
 tb/tb_regfile_mp.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam int unsigned RF_NRD   = 2;

    function automatic int unsigned rf_aw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Register 0 is read-only zero when zero_reg is set; out-of-range addresses are never writable.
    function automatic logic rf_writable(input int unsigned addr, input int unsigned nregs,
                                         input logic zero_reg);
        return (addr < nregs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, writeback, issue and scoreboard signals of the multi-port register file.
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN,
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned NRD   = RF_NRD
);
    localparam int unsigned AW = rf_aw(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: range check, zero-register masking, write bypass and busy masking.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned AW       = rf_aw(RF_NREGS),
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [NREGS-1:0]           busy_vec,
    input  logic [AW-1:0]              addr,
    input  logic                       wr_hit,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       iss_hit,
    input  logic [AW-1:0]              iss_addr,
    output logic [XLEN-1:0]            data,
    output logic                       pending
);

    logic readable;
    logic byp;

    assign readable = rf_writable(32'(addr), NREGS, ZERO_REG);
    // A same-cycle issue to this register means a newer producer is in flight, so no forwarding.
    assign byp = BYPASS && wr_hit && (addr == wr_addr) && !(iss_hit && (iss_addr == addr));

    always_comb begin
        data    = '0;
        pending = 1'b0;
        if (readable) begin
            data    = byp ? wr_data : regs[addr];
            pending = busy_vec[addr] & ~byp;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NRD read ports, one writeback port and a busy scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned NRD      = RF_NRD,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int unsigned AW = rf_aw(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic                       wr_ok;
    logic                       iss_ok;
    logic                       wr_hit;

    assign wr_ok  = bus.wr_en  && rf_writable(32'(bus.wr_addr), NREGS, ZERO_REG);
    assign iss_ok = bus.iss_en && rf_writable(32'(bus.iss_addr), NREGS, ZERO_REG);
    // Reads must return zero while reset is held, so forwarding is disabled then.
    assign wr_hit = wr_ok && rst;

    // Storage and scoreboard; issue is applied last so it wins over a same-register writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[bus.wr_addr] <= bus.wr_data;
                busy[bus.wr_addr] <= 1'b0;
            end
            if (iss_ok) begin
                busy[bus.iss_addr] <= 1'b1;
            end
        end
    end

    assign bus.busy_vec = busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .regs     (regs),
            .busy_vec (busy),
            .addr     (bus.rd_addr[k*AW +: AW]),
            .wr_hit   (wr_hit),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .iss_hit  (iss_ok),
            .iss_addr (bus.iss_addr),
            .data     (bus.rd_data[k*XLEN +: XLEN]),
            .pending  (bus.rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: no-bypass, bypass and a 24-register/3-port configuration.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) i0 ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) i1 ();
    regfile_mp_if #(.XLEN(32), .NREGS(24), .NRD(3)) i2 ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(i0));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(i1));
    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(i2));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        i0.wr_en = 1'b0; i0.iss_en = 1'b0; i0.wr_addr = '0; i0.iss_addr = '0; i0.wr_data = '0;
        i1.wr_en = 1'b0; i1.iss_en = 1'b0; i1.wr_addr = '0; i1.iss_addr = '0; i1.wr_data = '0;
        i2.wr_en = 1'b0; i2.iss_en = 1'b0; i2.wr_addr = '0; i2.iss_addr = '0; i2.wr_data = '0;
    endtask

    initial begin
        // Reset held three cycles, with a bypass-capable write attempted on u1
        rst = 1'b0;
        idle_all();
        i0.rd_addr = {5'd31, 5'd5};
        i1.rd_addr = {5'd31, 5'd5};
        i2.rd_addr = {5'd5, 5'd31, 5'd5};
        i1.wr_en = 1'b1; i1.wr_addr = 5'd5; i1.wr_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_i0_data", 128'(i0.rd_data), 128'h0);
        chk("rst_i0_busy", 128'(i0.rd_busy), 128'h0);
        chk("rst_i0_vec",  128'(i0.busy_vec), 128'h0);
        chk("rst_i1_data", 128'(i1.rd_data), 128'h0);
        chk("rst_i1_busy", 128'(i1.rd_busy), 128'h0);
        chk("rst_i2_vec",  128'(i2.busy_vec), 128'h0);

        @(negedge clk);
        idle_all();
        rst = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_i0", 128'(i0.rd_data), 128'h0);
        chk("post_rst_i1", 128'(i1.rd_data), 128'h0);
        chk("post_rst_vec", 128'(i1.busy_vec), 128'h0);

        // Write/read without bypass
        @(negedge clk);
        i0.wr_en = 1'b1; i0.wr_addr = 5'd7; i0.wr_data = 32'hDEAD_BEEF;
        i0.rd_addr = {5'd31, 5'd7};
        #1;
        chk("nobyp_same_cycle", 128'(i0.rd_data), 128'h0);
        @(negedge clk);
        idle_all();
        i0.rd_addr = {5'd7, 5'd7};
        #1;
        chk("nobyp_next_cycle", 128'(i0.rd_data), 128'hDEAD_BEEF_DEAD_BEEF);

        // Zero register: write and issue to reg 0 with bypass enabled
        @(negedge clk);
        i1.wr_en = 1'b1; i1.wr_addr = 5'd0; i1.wr_data = 32'h1234_5678;
        i1.iss_en = 1'b1; i1.iss_addr = 5'd0;
        i1.rd_addr = {5'd0, 5'd0};
        #1;
        chk("zero_same_data", 128'(i1.rd_data), 128'h0);
        chk("zero_same_busy", 128'(i1.rd_busy), 128'h0);
        @(negedge clk);
        idle_all();
        #1;
        chk("zero_next_data", 128'(i1.rd_data), 128'h0);
        chk("zero_next_vec",  128'(i1.busy_vec), 128'h0);

        // Bypass: issue reg 3, then write it back while port1 reads it
        @(negedge clk);
        i1.iss_en = 1'b1; i1.iss_addr = 5'd3;
        @(negedge clk);
        idle_all();
        i1.rd_addr = {5'd3, 5'd0};
        #1;
        chk("issue3_vec",  128'(i1.busy_vec), 128'h8);
        chk("issue3_busy", 128'(i1.rd_busy), 128'h2);
        i1.wr_en = 1'b1; i1.wr_addr = 5'd3; i1.wr_data = 32'hA5A5_A5A5;
        #1;
        chk("byp_data", 128'(i1.rd_data[63:32]), 128'hA5A5_A5A5);
        chk("byp_busy", 128'(i1.rd_busy), 128'h0);
        @(negedge clk);
        idle_all();
        #1;
        chk("byp_next_vec",  128'(i1.busy_vec), 128'h0);
        chk("byp_next_data", 128'(i1.rd_data), {64'h0, 32'hA5A5_A5A5, 32'h0});

        // Simultaneous issue and writeback to reg 9
        @(negedge clk);
        i1.iss_en = 1'b1; i1.iss_addr = 5'd9;
        @(negedge clk);
        i1.iss_en = 1'b1; i1.iss_addr = 5'd9;
        i1.wr_en = 1'b1; i1.wr_addr = 5'd9; i1.wr_data = 32'h55;
        i1.rd_addr = {5'd3, 5'd9};
        #1;
        chk("iss_wb_busy", 128'(i1.rd_busy), 128'h1);
        @(negedge clk);
        idle_all();
        #1;
        chk("iss_wb_data", 128'(i1.rd_data), {64'h0, 32'hA5A5_A5A5, 32'h55});
        chk("iss_wb_vec",  128'(i1.busy_vec), 128'h200);
        chk("iss_wb_rdb",  128'(i1.rd_busy), 128'h1);

        // Writeback to a register that is not busy
        @(negedge clk);
        i1.wr_en = 1'b1; i1.wr_addr = 5'd12; i1.wr_data = 32'h77;
        @(negedge clk);
        idle_all();
        i1.rd_addr = {5'd12, 5'd9};
        #1;
        chk("wb_free_data", 128'(i1.rd_data), {64'h0, 32'h77, 32'h55});
        chk("wb_free_vec",  128'(i1.busy_vec), 128'h200);

        // 24 registers, 3 ports: out-of-range write/issue ignored
        @(negedge clk);
        i2.wr_en = 1'b1; i2.wr_addr = 5'd23; i2.wr_data = 32'hCAFE;
        i2.iss_en = 1'b1; i2.iss_addr = 5'd5;
        @(negedge clk);
        idle_all();
        i2.wr_en = 1'b1; i2.wr_addr = 5'd30; i2.wr_data = 32'hBAD;
        i2.iss_en = 1'b1; i2.iss_addr = 5'd30;
        i2.rd_addr = {5'd30, 5'd30, 5'd30};
        #1;
        chk("oor_data", 128'(i2.rd_data), 128'h0);
        chk("oor_busy", 128'(i2.rd_busy), 128'h0);
        @(negedge clk);
        idle_all();
        i2.rd_addr = {5'd23, 5'd5, 5'd6};
        #1;
        chk("oor_next_vec",  128'(i2.busy_vec), 128'h20);
        chk("oor_next_data", 128'(i2.rd_data), {32'h0, 32'hCAFE, 32'h0, 32'h0});
        chk("oor_next_busy", 128'(i2.rd_busy), 128'h2);

        // Reset asserted mid-operation clears state without waiting for a clock
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_vec",  128'(i1.busy_vec), 128'h0);
        chk("midrst_data", 128'(i1.rd_data), 128'h0);
        chk("midrst_i2",   128'(i2.rd_data), 128'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
